// File: rtl/noc_fifo_rr_sched_pkg.sv
// Shared state encoding and index helpers for the NoC round-robin FIFO scheduler.
// MAXREQ bounds the number of requesters any instance may use.
package noc_sched_pkg;

   localparam int MAXREQ = 16;
   localparam int MAXIW  = 4;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   function automatic logic [MAXREQ-1:0] onehot(input logic [MAXIW-1:0] idx);
      logic [MAXREQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/noc_fifo_rr_sched_if.sv
// FIFO-side and output-stream handshake bundle of the round-robin scheduler.
// The slave modport is the scheduler's view; the master modport drives the FIFOs and the sink.
interface noc_fifo_rr_sched_if #(
   parameter int NREQ = 4,
   parameter int WID  = 32
) ();

   logic [NREQ-1:0]     fifo_empty;
   logic [NREQ*WID-1:0] fifo_dout;
   logic [NREQ-1:0]     fifo_readout;
   logic                out_vld;
   logic [WID-1:0]      out_data;
   logic                out_ready;

   modport master (
      output fifo_empty, fifo_dout, out_ready,
      input  fifo_readout, out_vld, out_data
   );

   modport slave (
      input  fifo_empty, fifo_dout, out_ready,
      output fifo_readout, out_vld, out_data
   );

endinterface

// File: rtl/noc_fifo_rr_sched_pick.sv
// Combinational round-robin picker: first requester found searching upward from last+1 with wrap.
module noc_rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic            vld,
   output logic [IW-1:0]   idx
);

   // Walk from the farthest candidate to the nearest so the nearest hit overwrites.
   always_comb begin
      vld = 1'b0;
      idx = '0;
      for (int k = NREQ; k >= 1; k--) begin
         if (req[IW'((int'(last) + k) % NREQ)]) begin
            vld = 1'b1;
            idx = IW'((int'(last) + k) % NREQ);
         end
      end
   end

endmodule

// File: rtl/noc_fifo_rr_sched.sv
// Round-robin drain of NREQ ingress FIFOs into one registered valid/ready stream,
// holding the grant on one FIFO until its packet-last word is forwarded or the lock times out.
module noc_fifo_rr_sched
   import noc_sched_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int WID     = 32,
   parameter int LASTPOS = WID - 1,
   parameter int TMO     = 255,
   parameter int TWID    = $clog2(TMO + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 softreset,
   noc_fifo_rr_sched_if.slave   bus,
   output logic [NREQ-1:0]      grant,
   output logic                 busy,
   output logic                 err_timeout
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_e            r_state, w_state_nxt;
   logic [IW-1:0]     r_own, w_own_nxt;
   logic [IW-1:0]     r_last, w_last_nxt;
   logic [TWID-1:0]   r_tmo, w_tmo_nxt, w_tmo_inc;
   logic              r_out_vld;
   logic [WID-1:0]    r_out_data;
   logic [NREQ-1:0]   r_grant;
   logic              r_err;

   logic              w_load, w_pop, w_err_set, w_pick_vld;
   logic [IW-1:0]     w_pick_idx, w_sel_idx;
   logic [WID-1:0]    w_word;
   logic [MAXREQ-1:0] w_oh_sel, w_oh_own;

   noc_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req  (~bus.fifo_empty),
      .last (r_last),
      .vld  (w_pick_vld),
      .idx  (w_pick_idx)
   );

   assign w_load    = !r_out_vld || bus.out_ready;
   assign w_sel_idx = (r_state == ST_IDLE) ? w_pick_idx : r_own;
   assign w_word    = bus.fifo_dout[w_sel_idx*WID +: WID];
   assign w_tmo_inc = r_tmo + 1'b1;
   assign w_oh_sel  = onehot(MAXIW'(w_sel_idx));
   assign w_oh_own  = onehot(MAXIW'(w_own_nxt));

   always_comb begin
      w_state_nxt = r_state;
      w_own_nxt   = r_own;
      w_last_nxt  = r_last;
      w_tmo_nxt   = r_tmo;
      w_pop       = 1'b0;
      w_err_set   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_load && w_pick_vld) begin
               w_pop = 1'b1;
               if (w_word[LASTPOS]) begin
                  w_last_nxt = w_pick_idx;
               end else begin
                  w_state_nxt = ST_LOCKED;
                  w_own_nxt   = w_pick_idx;
                  w_tmo_nxt   = '0;
               end
            end
         end
         ST_LOCKED: begin
            // Only the owner may be popped; an empty owner burns the timeout budget.
            if (!bus.fifo_empty[r_own]) begin
               if (w_load) begin
                  w_pop     = 1'b1;
                  w_tmo_nxt = '0;
                  if (w_word[LASTPOS]) begin
                     w_state_nxt = ST_IDLE;
                     w_last_nxt  = r_own;
                  end
               end
            end else if (w_tmo_inc == TWID'(TMO)) begin
               w_state_nxt = ST_IDLE;
               w_last_nxt  = r_own;
               w_tmo_nxt   = '0;
               w_err_set   = 1'b1;
            end else begin
               w_tmo_nxt = w_tmo_inc;
            end
         end
         default: ;
      endcase
      // A clearing cycle must not lose a word from any FIFO.
      if (softreset) w_pop = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_own      <= '0;
         r_last     <= IW'(NREQ - 1);
         r_tmo      <= '0;
         r_out_vld  <= 1'b0;
         r_out_data <= '0;
         r_grant    <= '0;
         r_err      <= 1'b0;
      end else if (softreset) begin
         r_state    <= ST_IDLE;
         r_own      <= '0;
         r_last     <= IW'(NREQ - 1);
         r_tmo      <= '0;
         r_out_vld  <= 1'b0;
         r_out_data <= '0;
         r_grant    <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_own   <= w_own_nxt;
         r_last  <= w_last_nxt;
         r_tmo   <= w_tmo_nxt;
         r_grant <= (w_state_nxt == ST_LOCKED) ? w_oh_own[NREQ-1:0] : '0;
         if (w_load) r_out_vld <= w_pop;
         if (w_pop) r_out_data <= w_word;
         if (w_err_set) r_err <= 1'b1;
      end
   end

   assign bus.fifo_readout = w_pop ? w_oh_sel[NREQ-1:0] : '0;
   assign bus.out_vld      = r_out_vld;
   assign bus.out_data     = r_out_data;
   assign grant            = r_grant;
   assign busy             = (r_state == ST_LOCKED) || r_out_vld;
   assign err_timeout      = r_err;

endmodule

// File: tb/tb_noc_fifo_rr_sched.sv
// Bench for noc_fifo_rr_sched: vector table, hand-written corner sequences and a
// randomized packet-level round-robin reference.
module tb_noc_fifo_rr_sched;
   import noc_sched_pkg::*;

   localparam int NREQ = 4;
   localparam int WID  = 32;
   localparam int TMO  = 4;
   localparam logic [WID-1:0] LF = 32'h8000_0000;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            softreset = 1'b0;
   logic [NREQ-1:0] grant;
   logic            busy, err_timeout;

   noc_fifo_rr_sched_if #(.NREQ(NREQ), .WID(WID)) bus ();

   noc_fifo_rr_sched #(.NREQ(NREQ), .WID(WID), .LASTPOS(WID-1), .TMO(TMO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .softreset   (softreset),
      .bus         (bus),
      .grant       (grant),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   logic [WID-1:0]  q[NREQ][$];
   logic [NREQ-1:0] rd_cap;
   int              n_chk = 0;
   int              n_fail = 0;

   typedef struct {
      int              pre;
      logic            rdy;
      logic [NREQ-1:0] rd;
      logic            vld;
      logic [WID-1:0]  data;
      logic [NREQ-1:0] gnt;
   } vec_t;
   vec_t tv[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         bus.fifo_empty[i] = (q[i].size() == 0);
         bus.fifo_dout[i*WID +: WID] = (q[i].size() == 0) ? '0 : q[i][0];
      end
   endtask

   // Called at a negedge with inputs settled; returns at the next negedge with pops applied.
   task automatic tick();
      rd_cap = bus.fifo_readout;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++)
         if (rd_cap[i] && q[i].size() > 0) void'(q[i].pop_front());
      drive();
      @(negedge clk);
   endtask

   task automatic do_soft();
      softreset = 1'b1;
      #1;
      tick();
      softreset = 1'b0;
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      for (int c = 0; c < 100; c++) begin
         drive();
         #1;
         if (q[0].size() + q[1].size() + q[2].size() + q[3].size() == 0 && !bus.out_vld && !busy) break;
         tick();
      end
      chk("drain_empty", 64'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 0);
   endtask

   function automatic void add(input int pre, input logic rdy, input logic [NREQ-1:0] rd,
                               input logic vld, input logic [WID-1:0] data, input logic [NREQ-1:0] gnt);
      vec_t v;
      v.pre = pre; v.rdy = rdy; v.rd = rd; v.vld = vld; v.data = data; v.gnt = gnt;
      tv.push_back(v);
   endfunction

   int              plen[NREQ][$];
   logic [WID-1:0]  mq[NREQ][$];
   logic [WID-1:0]  expq[$];
   logic            prev_vld, prev_rdy;
   logic [WID-1:0]  prev_data;

   initial begin
      // Single-beat words from 0 and 2, then a 3-beat burst on 1 racing a single beat on 3.
      add(1, 1'b1, 4'b0001, 1'b0, '0,             4'b0000);
      add(0, 1'b1, 4'b0100, 1'b1, LF | 32'hA0,    4'b0000);
      add(0, 1'b1, 4'b0000, 1'b1, LF | 32'hC2,    4'b0000);
      add(0, 1'b1, 4'b0000, 1'b0, '0,             4'b0000);
      add(2, 1'b1, 4'b0010, 1'b0, '0,             4'b0000);
      add(0, 1'b1, 4'b0010, 1'b1, 32'hB0,         4'b0010);
      add(0, 1'b1, 4'b0010, 1'b1, 32'hB1,         4'b0010);
      add(0, 1'b1, 4'b1000, 1'b1, LF | 32'hB2,    4'b0000);
      add(0, 1'b1, 4'b0000, 1'b1, LF | 32'hD3,    4'b0000);
      add(0, 1'b1, 4'b0000, 1'b0, '0,             4'b0000);

      bus.out_ready = 1'b1;
      drive();
      @(negedge clk);
      @(negedge clk);
      chk("rst_vld", 64'(bus.out_vld), 0);
      chk("rst_data", 64'(bus.out_data), 0);
      chk("rst_grant", 64'(grant), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_err", 64'(err_timeout), 0);
      rst_n = 1'b1;
      #1;

      foreach (tv[k]) begin
         if (tv[k].pre == 1) begin
            q[0].push_back(LF | 32'hA0);
            q[2].push_back(LF | 32'hC2);
         end else if (tv[k].pre == 2) begin
            do_soft();
            q[1].push_back(32'hB0);
            q[1].push_back(32'hB1);
            q[1].push_back(LF | 32'hB2);
            q[3].push_back(LF | 32'hD3);
         end
         bus.out_ready = tv[k].rdy;
         drive();
         #1;
         chk($sformatf("tv%0d_readout", k), 64'(bus.fifo_readout), 64'(tv[k].rd));
         chk($sformatf("tv%0d_vld", k), 64'(bus.out_vld), 64'(tv[k].vld));
         if (tv[k].vld) chk($sformatf("tv%0d_data", k), 64'(bus.out_data), 64'(tv[k].data));
         chk($sformatf("tv%0d_grant", k), 64'(grant), 64'(tv[k].gnt));
         tick();
      end

      // Backpressure: hold out_ready low for 5 cycles with a word parked on the output.
      q[2].push_back(LF | 32'hF0);
      q[2].push_back(LF | 32'hF1);
      bus.out_ready = 1'b0;
      drive();
      #1;
      chk("bp_first_pop", 64'(bus.fifo_readout), 64'(4'b0100));
      tick();
      for (int s = 0; s < 5; s++) begin
         chk("bp_vld", 64'(bus.out_vld), 1);
         chk("bp_data", 64'(bus.out_data), 64'(LF | 32'hF0));
         chk("bp_readout", 64'(bus.fifo_readout), 0);
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_resume_pop", 64'(bus.fifo_readout), 64'(4'b0100));
      tick();
      chk("bp_next_data", 64'(bus.out_data), 64'(LF | 32'hF1));
      tick();
      chk("bp_vld_drop", 64'(bus.out_vld), 0);

      // Owner 3 runs dry mid-burst while requester 0 waits.
      q[3].push_back(32'h0000_00E3);
      q[0].push_back(LF | 32'h0000_00E0);
      drive();
      #1;
      chk("tmo_lock_pop", 64'(bus.fifo_readout), 64'(4'b1000));
      tick();
      for (int s = 1; s <= TMO; s++) begin
         chk($sformatf("tmo_stall%0d_readout", s), 64'(bus.fifo_readout), 0);
         chk($sformatf("tmo_stall%0d_grant", s), 64'(grant), 64'(4'b1000));
         chk($sformatf("tmo_stall%0d_err", s), 64'(err_timeout), 0);
         tick();
      end
      chk("tmo_err_set", 64'(err_timeout), 1);
      chk("tmo_idle_grant", 64'(grant), 0);
      chk("tmo_next_req0", 64'(bus.fifo_readout), 64'(4'b0001));
      tick();
      chk("tmo_req0_data", 64'(bus.out_data), 64'(LF | 32'h0000_00E0));
      tick();

      // softreset while LOCKED with a word on the output.
      q[1].push_back(32'h0000_0A10);
      q[1].push_back(32'h0000_0A11);
      q[1].push_back(LF | 32'h0000_0A12);
      drive();
      #1;
      chk("sr_lock_pop", 64'(bus.fifo_readout), 64'(4'b0010));
      tick();
      chk("sr_locked_grant", 64'(grant), 64'(4'b0010));
      chk("sr_locked_vld", 64'(bus.out_vld), 1);
      softreset = 1'b1;
      #1;
      chk("sr_no_pop", 64'(bus.fifo_readout), 0);
      tick();
      softreset = 1'b0;
      q[0].push_back(32'h0000_0B00);
      q[0].push_back(LF | 32'h0000_0B01);
      drive();
      #1;
      chk("sr_vld", 64'(bus.out_vld), 0);
      chk("sr_grant", 64'(grant), 0);
      chk("sr_err", 64'(err_timeout), 0);
      chk("sr_first_req0", 64'(bus.fifo_readout), 64'(4'b0001));
      tick();
      chk("sr_grant_req0", 64'(grant), 64'(4'b0001));
      chk("sr_data_req0", 64'(bus.out_data), 64'(32'h0000_0B00));
      drain();

      // Randomized preloaded packets against a packet-level round-robin reference.
      for (int round = 0; round < 4; round++) begin
         do_soft();
         expq.delete();
         for (int r = 0; r < NREQ; r++) begin
            plen[r].delete();
            mq[r].delete();
            for (int p = $urandom_range(0, 3); p > 0; p--) begin
               int len;
               len = $urandom_range(1, 4);
               plen[r].push_back(len);
               for (int b = 0; b < len; b++) begin
                  logic [WID-1:0] w;
                  w = {(b == len - 1), 31'($urandom)};
                  q[r].push_back(w);
                  mq[r].push_back(w);
               end
            end
         end
         begin
            int lst;
            int found;
            lst = NREQ - 1;
            found = 1;
            while (found != 0) begin
               found = 0;
               for (int k = 1; k <= NREQ && found == 0; k++) begin
                  int r;
                  r = (lst + k) % NREQ;
                  if (plen[r].size() > 0) begin
                     int len;
                     len = plen[r].pop_front();
                     for (int b = 0; b < len; b++) expq.push_back(mq[r].pop_front());
                     lst = r;
                     found = 1;
                  end
               end
            end
         end
         prev_vld = 1'b0;
         prev_rdy = 1'b1;
         prev_data = '0;
         for (int c = 0; c < 800 && (expq.size() > 0 || bus.out_vld); c++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            drive();
            #1;
            chk("rnd_readout_onehot", 64'($countones(bus.fifo_readout) <= 1), 1);
            chk("rnd_readout_nonempty", 64'(bus.fifo_readout & bus.fifo_empty), 0);
            chk("rnd_grant_onehot", 64'($countones(grant) <= 1), 1);
            if (prev_vld && !prev_rdy) begin
               chk("rnd_hold_vld", 64'(bus.out_vld), 1);
               chk("rnd_hold_data", 64'(bus.out_data), 64'(prev_data));
            end
            if (bus.out_vld && bus.out_ready) begin
               if (expq.size() == 0) chk("rnd_extra_word", 64'(bus.out_data), 64'hDEAD_BEEF_0000_0000);
               else chk("rnd_data", 64'(bus.out_data), 64'(expq.pop_front()));
            end
            prev_vld = bus.out_vld;
            prev_rdy = bus.out_ready;
            prev_data = bus.out_data;
            tick();
         end
         chk("rnd_words_left", 64'(expq.size()), 0);
         chk("rnd_no_timeout", 64'(err_timeout), 0);
         drain();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/noc_fifo_rr_sched.md
# noc_fifo_rr_sched

Round-robin scheduler that drains NREQ sampled sync FIFOs, one per NoC input port, into a single registered output stream with a valid/ready handshake. It drives each FIFO's readout and keeps the grant locked to one FIFO until a word carrying the packet-last flag has been forwarded, so multi-beat AXI bursts are never interleaved. It sits between the per-port ingress FIFOs and the shared NoC link/crossbar stage. A lock timeout prevents a stalled owner from starving the other ports.

## Interface
- NREQ, 4, number of requesting FIFOs (2..16)
- WID, 32, FIFO word width including flag bits
- LASTPOS, WID-1, bit index of the packet-last flag inside a word
- TMO, 255, maximum cycles a lock may wait on an empty owner (≥1)
- TWID, $clog2(TMO+1), width of the timeout counter
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- softreset  in  1  synchronous clear of all state; same values as reset
- fifo_empty  in  NREQ  per-FIFO empty; the matching word is valid when low
- fifo_dout  in  NREQ*WID  per-FIFO head word; requester i occupies bits [i*WID +: WID]
- fifo_readout  out  NREQ  per-FIFO pop strobe, combinational
- out_vld  out  1  output word valid, registered
- out_data  out  WID  output word, registered
- out_ready  in  1  downstream accepts out_data when out_vld is high
- grant  out  NREQ  one-hot owner while locked; 0 in IDLE; registered
- busy  out  1  high while LOCKED or out_vld is high
- err_timeout  out  1  sticky; set when a lock is force-released; cleared only by reset or softreset

## Operation
- load = !out_vld || out_ready. A new word may be taken only when load is high.
- States:
  - IDLE: no owner.
  - LOCKED: owner index `own`, grant = onehot(own).
- IDLE, load, any fifo_empty low:
  - Pick the winner by round-robin, searching from (last+1) mod NREQ upward with wrap.
  - Assert fifo_readout[winner] and capture fifo_dout[winner] into out_data.
  - If the word's last flag is 1: stay in IDLE and set last = winner.
  - Otherwise: go to LOCKED with own = winner.
- LOCKED, load, !fifo_empty[own]:
  - Pop and forward the owner's word.
  - If its last flag is 1: go to IDLE and set last = own.
- LOCKED, fifo_empty[own]:
  - No pop. tmo_cnt increments each cycle.
  - When tmo_cnt reaches TMO: go to IDLE, set last = own, set err_timeout.
- tmo_cnt clears on every owner pop and on every entry to LOCKED.
- At most one fifo_readout bit is high per cycle. fifo_readout is never asserted toward an empty FIFO.
- Words pass through unmodified. The last flag stays inside out_data.
- Non-owner FIFOs are never popped while LOCKED, even if out_ready is high and the owner is empty.

## Timing
- Latency is 1 cycle: a word popped in cycle n appears on out_data/out_vld in cycle n+1.
- Full throughput: one word per cycle while out_ready stays high and the source is non-empty.
- out_vld/out_data hold stable while out_vld && !out_ready (AXI-style; no retraction).
- out_vld drops the cycle after an accepted transfer when no new word is loaded.
- A single-beat packet (last=1) does not lock. Back-to-back single-beat packets from different FIFOs rotate every cycle.
- Reset/softreset values:
  - out_vld=0, out_data=0, grant=0, busy=0, err_timeout=0
  - state IDLE, tmo_cnt=0
  - last=NREQ-1, so requester 0 has first priority.
- Reset asserted mid-packet abandons the lock. The word held in out_data is discarded.
- softreset has priority over every event in the same cycle.

## Structure
- Package noc_sched_pkg holds the state encoding (IDLE, LOCKED) and a onehot/index helper function.
- One sub-module: noc_rr_pick. It is combinational; inputs are req[NREQ] and last index; outputs are a valid flag and the winner index. Search order starts at last+1 with wrap.
- The top level holds the FSM, output register, timeout counter and the readout decode.

## Test plan
- Reset, then requesters 0 and 2 each hold one single-beat word (last=1), out_ready=1. Required: out_data = req0 word then req2 word on consecutive cycles; grant stays 0; fifo_readout = 0001 then 0100.
- Requester 1 holds a 3-beat burst and requester 3 holds 1 beat, both present at once. Required: beats 1a, 1b, 1c, then 3a; grant = 0010 for the burst; readout[3] stays 0 until after 1c.
- Backpressure: out_ready=0 for 5 cycles while out_vld=1. Required: out_data is stable, fifo_readout=0 throughout, and the next word follows 1 cycle after out_ready rises.
- Owner empties mid-burst with TMO=4 while requester 0 has data. Required: 4 stall cycles, then err_timeout=1, IDLE, and requester 0 is served next.
- Assert softreset while LOCKED with out_vld=1. Required: next cycle out_vld=0, grant=0, err_timeout=0; the first grant afterwards goes to requester 0.
